// File: rtl/alu_pkg.sv
// alu_pkg: opcode/mode encodings, instruction field positions and sequencer states shared by the ALU and its sequencer.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_XNOR = 4'd4;
    localparam logic [3:0] OP_SGT  = 4'd5;
    localparam logic [3:0] OP_CMP  = 4'd6;

    localparam logic [1:0] MODE_USER = 2'd0;
    localparam logic [1:0] MODE_JUMP = 2'd1;
    localparam logic [1:0] MODE_RSVD = 2'd2;
    localparam logic [1:0] MODE_HALT = 2'd3;

    localparam int OPC_LO  = 28;
    localparam int MODE_LO = 26;
    localparam int RD_LO   = 22;
    localparam int RS1_LO  = 18;
    localparam int RS2_LO  = 14;
    localparam int SUP_BIT = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } seq_state_e;

    // Only user-mode arithmetic/logic results land in the register file.
    function automatic logic writes_back(input logic [1:0] mode, input logic [3:0] op);
        return mode == MODE_USER && op >= OP_ADD && op <= OP_SGT;
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: sequencer register file, two combinational reads, one write, r0 hardwired to zero.
module seq_regfile #(
    parameter int WORD_W = 32,
    parameter int NREGS  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [WORD_W-1:0]        wdata_i,
    input  logic [$clog2(NREGS)-1:0] raddr1_i,
    input  logic [$clog2(NREGS)-1:0] raddr2_i,
    output logic [WORD_W-1:0]        rdata1_o,
    output logic [WORD_W-1:0]        rdata2_o
);

    logic [WORD_W-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches instructions over req/ack, drives the ALU from a local register file,
// writes results back and redirects the PC on taken jumps.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PC_W   = 10,
    parameter int NREGS  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cfg_we,
    input  logic [$clog2(NREGS)-1:0] cfg_addr,
    input  logic [WORD_W-1:0]        cfg_data,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic                     imem_ack,
    input  logic [WORD_W-1:0]        imem_data,
    output logic [WORD_W-1:0]        alu_data_1,
    output logic [WORD_W-1:0]        alu_data_2,
    output logic [3:0]               alu_opcode,
    output logic [1:0]               alu_mode,
    output logic                     alu_enable,
    output logic                     alu_zero,
    input  logic [WORD_W-1:0]        alu_result,
    input  logic                     alu_one,
    output logic                     busy,
    output logic                     halted
);

    localparam int AW = $clog2(NREGS);

    seq_state_e        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, res_q, d1_q, d2_q;
    logic [WORD_W-1:0] rd1, rd2, wdata;
    logic [3:0]        op_q, ir_op;
    logic [1:0]        mode_q, ir_mode;
    logic              one_q, rf_we, unused_ir;
    logic [AW-1:0]     ir_rd, ir_rs1, ir_rs2, waddr;

    assign ir_op   = ir_q[OPC_LO +: 4];
    assign ir_mode = ir_q[MODE_LO +: 2];
    assign ir_rd   = ir_q[RD_LO +: AW];
    assign ir_rs1  = ir_q[RS1_LO +: AW];
    assign ir_rs2  = ir_q[RS2_LO +: AW];
    assign unused_ir = ^ir_q[SUP_BIT-1:PC_W];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH:  state_d = imem_ack ? S_DECODE : S_FETCH;
            S_DECODE: state_d = (ir_mode == MODE_HALT) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = (ir_mode == MODE_JUMP && one_q) ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
            end
            default:  state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ALU-facing registers only move on their own state's edge, so they hold everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            op_q   <= '0;
            mode_q <= '0;
            res_q  <= '0;
            one_q  <= 1'b0;
        end else begin
            if (state_q == S_FETCH && imem_ack) ir_q <= imem_data;
            if (state_q == S_DECODE) begin
                d1_q   <= rd1;
                d2_q   <= rd2;
                op_q   <= ir_op;
                mode_q <= ir_mode;
            end
            if (state_q == S_EXEC) begin
                res_q <= alu_result;
                one_q <= alu_one;
            end
        end
    end

    assign rf_we = (state_q == S_IDLE && cfg_we) || (state_q == S_WB && writes_back(ir_mode, ir_op));
    assign waddr = (state_q == S_IDLE) ? cfg_addr : ir_rd;
    assign wdata = (state_q == S_IDLE) ? cfg_data : res_q;

    seq_regfile #(
        .WORD_W (WORD_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (rf_we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .raddr1_i (ir_rs1),
        .raddr2_i (ir_rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    assign imem_req   = state_q == S_FETCH;
    assign imem_addr  = pc_q;
    assign alu_data_1 = d1_q;
    assign alu_data_2 = d2_q;
    assign alu_opcode = op_q;
    assign alu_mode   = mode_q;
    assign alu_enable = state_q == S_EXEC;
    assign alu_zero   = !((state_q inside {S_DECODE, S_EXEC, S_WB}) && !ir_q[SUP_BIT]);
    assign busy       = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
    assign halted     = state_q == S_HALT;

endmodule
